// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding I-mem requests, 2-entry return queue, DE latch.
// Optional FETCH_BUBBLE_CNT_EN adds BUBBLE_CNT, counting DE loads that leave DE_V low.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        V_MEM_STALL,
    input  logic        V_DE_BR_STALL,
    input  logic        BR_RESOLVE_V,
    input  logic        BR_TAKEN,
    input  logic [63:0] BR_TARGET,
    input  logic        TRAP_V,
    input  logic [63:0] TRAP_PC,
    output logic        IMEM_REQ,
    output logic [63:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic [63:0] DE_NPC,
    output logic [31:0] DE_IR,
    output logic        DE_V
`ifdef FETCH_BUBBLE_CNT_EN
    ,
    output logic [63:0] BUBBLE_CNT
`endif
);
    typedef enum logic {FETCH, BR_WAIT} state_t;

    state_t      state, state_next;
    logic [63:0] pc, req_npc, fallthrough;
    logic        outstanding, discard;
    logic [63:0] q_npc [2];
    logic [31:0] q_ir  [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count, count_next;
    logic        redirect, br_detect, grant, resp_done, push, pop;

    always_comb begin
        redirect   = TRAP_V || BR_RESOLVE_V;
        br_detect  = DE_V && V_DE_BR_STALL && (state == FETCH) && !redirect;
        grant      = IMEM_REQ && IMEM_GNT;
        resp_done  = IMEM_RVALID && outstanding;
        push       = resp_done && !discard && !redirect && !br_detect;
        pop        = !V_MEM_STALL && (state == FETCH) && (count != 2'd0) && !redirect && !br_detect;
        count_next = count + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (redirect)
            state_next = FETCH;
        else if (br_detect)
            state_next = BR_WAIT;
    end

    always_comb begin
        IMEM_REQ  = !RESET && (state == FETCH) && !outstanding && (count != 2'd2) && !redirect;
        IMEM_ADDR = pc;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            q_npc[wr_ptr] <= req_npc;
            q_ir[wr_ptr]  <= IMEM_RDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc          <= RESET_PC;
            req_npc     <= '0;
            fallthrough <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= '0;
            DE_NPC      <= '0;
            DE_IR       <= '0;
            DE_V        <= 1'b0;
        end else begin
            count <= count_next;
            if (resp_done) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
            if (grant) begin
                pc          <= pc + 64'd4;
                req_npc     <= pc + 64'd4;
                outstanding <= 1'b1;
            end
            if (push)
                wr_ptr <= !wr_ptr;
            if (pop)
                rd_ptr <= !rd_ptr;
            if (!V_MEM_STALL) begin
                DE_V <= pop;
                if (pop) begin
                    DE_NPC <= q_npc[rd_ptr];
                    DE_IR  <= q_ir[rd_ptr];
                end
            end
            if (redirect || br_detect) begin
                count  <= '0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end
            // A response landing in the redirect cycle is already dropped, so only a
            // still-pending one (or one granted while a branch is detected) needs discard.
            if (TRAP_V) begin
                pc      <= TRAP_PC;
                discard <= outstanding && !IMEM_RVALID;
                DE_V    <= 1'b0;
            end else if (BR_RESOLVE_V) begin
                pc      <= BR_TAKEN ? BR_TARGET : fallthrough;
                discard <= outstanding && !IMEM_RVALID;
            end else if (br_detect) begin
                fallthrough <= DE_NPC;
                discard     <= (outstanding && !IMEM_RVALID) || grant;
            end
        end
    end

`ifdef FETCH_BUBBLE_CNT_EN
    always_ff @(posedge CLK) begin
        if (RESET)
            BUBBLE_CNT <= '0;
        else if (!V_MEM_STALL && !pop)
            BUBBLE_CNT <= BUBBLE_CNT + 64'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model with configurable latency plus a fetch scoreboard
// that predicts every DE delivery from the bench's own PC model.
module tb_fetch_stage;
    localparam logic [63:0] RST_PC = 64'h1000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        V_MEM_STALL = 1'b0;
    logic        V_DE_BR_STALL = 1'b0;
    logic        BR_RESOLVE_V = 1'b0;
    logic        BR_TAKEN = 1'b0;
    logic [63:0] BR_TARGET = '0;
    logic        TRAP_V = 1'b0;
    logic [63:0] TRAP_PC = '0;
    logic        IMEM_REQ;
    logic [63:0] IMEM_ADDR;
    logic        IMEM_GNT = 1'b1;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = '0;
    logic [63:0] DE_NPC;
    logic [31:0] DE_IR;
    logic        DE_V;
`ifdef FETCH_BUBBLE_CNT_EN
    logic [63:0] BUBBLE_CNT;
`endif

    int n_checks = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .CLK(CLK), .RESET(RESET), .V_MEM_STALL(V_MEM_STALL), .V_DE_BR_STALL(V_DE_BR_STALL),
        .BR_RESOLVE_V(BR_RESOLVE_V), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
        .TRAP_V(TRAP_V), .TRAP_PC(TRAP_PC), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_GNT(IMEM_GNT), .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .DE_NPC(DE_NPC), .DE_IR(DE_IR), .DE_V(DE_V)
`ifdef FETCH_BUBBLE_CNT_EN
        , .BUBBLE_CNT(BUBBLE_CNT)
`endif
    );

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    // Instruction memory: responds mem_lat cycles after the grant cycle.
    int          mem_lat = 1;
    int          pend_cnt = 0;
    logic [63:0] pend_addr = '0;

    always @(negedge CLK) begin
        if (RESET)
            pend_cnt = 0;
        else if (IMEM_REQ && IMEM_GNT) begin
            pend_addr = IMEM_ADDR;
            pend_cnt  = mem_lat;
        end
    end

    always @(posedge CLK) begin
        #1;
        IMEM_RVALID = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                IMEM_RVALID = 1'b1;
                IMEM_RDATA  = word_at(pend_addr);
            end
        end
    end

    // Scoreboard: push predicted {npc, ir} at each grant, pop on each fresh DE load.
    logic [95:0] sb[$];
    logic [63:0] m_pc = RST_PC;
    logic [63:0] last_npc = '0;
    logic [63:0] br_ft = '0;
    bit          in_brwait = 1'b0;
    bit          prev_stall = 1'b0;
    bit          prev_reset = 1'b1;

    always @(negedge CLK) begin
        logic [95:0] e;
        if (RESET) begin
            m_pc = RST_PC;
            sb.delete();
            in_brwait  = 1'b0;
            last_npc   = '0;
            prev_reset = 1'b1;
            prev_stall = 1'b0;
        end else begin
            if (!prev_reset && !prev_stall && DE_V) begin
                n_checks++;
                if (sb.size() == 0)
                    $display("FAIL de_extra: got npc=%h ir=%h, required no delivery", DE_NPC, DE_IR);
                else begin
                    e = sb.pop_front();
                    last_npc = e[95:32];
                    if ({DE_NPC, DE_IR} !== e)
                        $display("FAIL de_entry: got npc=%h ir=%h, required npc=%h ir=%h",
                                 DE_NPC, DE_IR, e[95:32], e[31:0]);
                    else
                        n_pass++;
                end
            end else if (!prev_reset && prev_stall && DE_V) begin
                n_checks++;
                if (DE_NPC !== last_npc)
                    $display("FAIL de_hold: got npc=%h, required %h", DE_NPC, last_npc);
                else
                    n_pass++;
            end
            if (in_brwait) begin
                n_checks++;
                if (DE_V !== 1'b0)
                    $display("FAIL brwait_de_v: got %b, required 0", DE_V);
                else
                    n_pass++;
            end
            if (TRAP_V) begin
                m_pc = TRAP_PC;
                sb.delete();
                in_brwait = 1'b0;
            end else if (BR_RESOLVE_V) begin
                m_pc = BR_TAKEN ? BR_TARGET : br_ft;
                sb.delete();
                in_brwait = 1'b0;
            end else begin
                if (IMEM_REQ && IMEM_GNT) begin
                    n_checks++;
                    if (IMEM_ADDR !== m_pc)
                        $display("FAIL req_addr: got %h, required %h", IMEM_ADDR, m_pc);
                    else
                        n_pass++;
                    if (!(V_DE_BR_STALL && !in_brwait))
                        sb.push_back({m_pc + 64'd4, word_at(m_pc)});
                    m_pc = m_pc + 64'd4;
                end
                if (V_DE_BR_STALL && !in_brwait) begin
                    br_ft = last_npc;
                    sb.delete();
                    in_brwait = 1'b1;
                end
            end
            prev_reset = 1'b0;
            prev_stall = V_MEM_STALL;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int lat);
        RESET = 1'b1;
        V_MEM_STALL = 1'b0;
        V_DE_BR_STALL = 1'b0;
        BR_RESOLVE_V = 1'b0;
        TRAP_V = 1'b0;
        mem_lat = lat;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic wait_de(input string name, input logic [63:0] npc);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (DE_V === 1'b1) begin
                seen = 1'b1;
                n_checks++;
                if (DE_NPC !== npc || DE_IR !== word_at(npc - 64'd4))
                    $display("FAIL %s: got npc=%h ir=%h, required npc=%h ir=%h",
                             name, DE_NPC, DE_IR, npc, word_at(npc - 64'd4));
                else
                    n_pass++;
            end
            tick();
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s_timeout: got no DE_V within 20 cycles, required delivery of %h", name, npc);
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_v = 8'b1010_1000;
        logic [63:0] exp_npc;
        RESET = 1'b1;
        mem_lat = 1;
        tick();
        tick();
        @(negedge CLK);
        n_checks++;
        if (IMEM_REQ !== 1'b0 || DE_V !== 1'b0 || DE_NPC !== 64'h0 || DE_IR !== 32'h0)
            $display("FAIL reset_state: got req=%b v=%b npc=%h ir=%h, required 0/0/0/0",
                     IMEM_REQ, DE_V, DE_NPC, DE_IR);
        else
            n_pass++;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (i % 2 == 0 && i < 6) begin
                n_checks++;
                if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== RST_PC + 64'(4 * (i / 2)))
                    $display("FAIL reset_fetch%0d: got req=%b addr=%h, required 1/%h",
                             i, IMEM_REQ, IMEM_ADDR, RST_PC + 64'(4 * (i / 2)));
                else
                    n_pass++;
            end
            exp_npc = RST_PC + 64'(4 * ((i - 1) / 2));
            n_checks++;
            if (DE_V !== exp_v[i] || (exp_v[i] && DE_NPC !== exp_npc))
                $display("FAIL reset_de%0d: got v=%b npc=%h, required v=%b npc=%h",
                         i, DE_V, DE_NPC, exp_v[i], exp_npc);
            else
                n_pass++;
            tick();
        end
    endtask

    task automatic test_mem_stall();
        V_MEM_STALL = 1'b1;
        repeat (4) tick();
        @(negedge CLK);
        n_checks++;
        if (IMEM_REQ !== 1'b0)
            $display("FAIL stall_req: got %b, required 0", IMEM_REQ);
        else
            n_pass++;
        tick();
        V_MEM_STALL = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            n_checks++;
            if (DE_V !== 1'b1)
                $display("FAIL stall_drain%0d: got v=%b, required 1", i, DE_V);
            else
                n_pass++;
            tick();
        end
        repeat (6) tick();
    endtask

    task automatic test_branch(input bit taken, input logic [63:0] target, input logic [63:0] exp_addr);
        bit found = 1'b0;
        do_reset(1);
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (DE_V === 1'b1 && DE_NPC === 64'h100C)
                found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            $display("FAIL br_find: got no DE_NPC=100C within 30 cycles, required it");
            return;
        end
        V_DE_BR_STALL = 1'b1;
        tick();
        V_DE_BR_STALL = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            n_checks++;
            if (IMEM_REQ !== 1'b0)
                $display("FAIL br_wait_req: got %b, required 0", IMEM_REQ);
            else
                n_pass++;
            tick();
        end
        BR_RESOLVE_V = 1'b1;
        BR_TAKEN = taken;
        BR_TARGET = target;
        tick();
        BR_RESOLVE_V = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== exp_addr)
            $display("FAIL br_redirect: got req=%b addr=%h, required 1/%h", IMEM_REQ, IMEM_ADDR, exp_addr);
        else
            n_pass++;
        wait_de("br_first_de", exp_addr + 64'd4);
    endtask

    task automatic test_trap();
        do_reset(3);
        tick();
        TRAP_V = 1'b1;
        TRAP_PC = 64'h8000;
        tick();
        TRAP_V = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (IMEM_ADDR !== 64'h8000 || IMEM_REQ !== 1'b0)
            $display("FAIL trap_addr: got req=%b addr=%h, required 0/8000", IMEM_REQ, IMEM_ADDR);
        else
            n_pass++;
        tick();
        tick();
        @(negedge CLK);
        n_checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h8000)
            $display("FAIL trap_refetch: got req=%b addr=%h, required 1/8000", IMEM_REQ, IMEM_ADDR);
        else
            n_pass++;
        wait_de("trap_first_de", 64'h8004);
    endtask

    task automatic test_trap_and_resolve();
        do_reset(1);
        tick();
        TRAP_V = 1'b1;
        TRAP_PC = 64'h8000;
        BR_RESOLVE_V = 1'b1;
        BR_TAKEN = 1'b1;
        BR_TARGET = 64'h2000;
        tick();
        TRAP_V = 1'b0;
        BR_RESOLVE_V = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 64'h8000)
            $display("FAIL trap_prio: got req=%b addr=%h, required 1/8000", IMEM_REQ, IMEM_ADDR);
        else
            n_pass++;
        wait_de("trap_prio_de", 64'h8004);
    endtask

`ifdef FETCH_BUBBLE_CNT_EN
    task automatic test_bubble_cnt();
        int empties = 0;
        do_reset(3);
        for (int i = 1; i <= 10; i++) begin
            tick();
            @(negedge CLK);
            if (DE_V === 1'b0)
                empties++;
        end
        n_checks++;
        if (BUBBLE_CNT !== 64'(empties))
            $display("FAIL bubble_cnt: got %0d, required %0d", BUBBLE_CNT, empties);
        else
            n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mem_stall();
        test_branch(1'b1, 64'h2000, 64'h2000);
        test_branch(1'b0, 64'h2000, 64'h100C);
        test_trap();
        test_trap_and_resolve();
`ifdef FETCH_BUBBLE_CNT_EN
        test_bubble_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage feeding the decode stage. Holds the PC, issues one-outstanding instruction-memory requests, buffers returned words in a 2-entry queue, and drives the DE pipeline latch (DE_NPC, DE_IR, DE_V). It honours the downstream memory stall, bubbles behind branches in decode until execute resolves them, and redirects to the trap vector when the CSR file signals a control switch.

## Interface
- RESET_PC, 64'h0, PC loaded on reset.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- V_MEM_STALL  in  1  downstream stall; DE latch holds its value.
- V_DE_BR_STALL  in  1  decode holds a conditional branch; qualified with DE_V.
- BR_RESOLVE_V  in  1  execute resolves the pending branch this cycle.
- BR_TAKEN  in  1  branch outcome, valid with BR_RESOLVE_V.
- BR_TARGET  in  64  taken target, valid with BR_RESOLVE_V.
- TRAP_V  in  1  control switch from the CSR file (DE_CS).
- TRAP_PC  in  64  trap vector (DE_MTVEC).
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  64  request address; equals PC.
- IMEM_GNT  in  1  request accepted this cycle.
- IMEM_RVALID  in  1  response valid.
- IMEM_RDATA  in  32  instruction word.
- DE_NPC  out  64  fetch address + 4 of the instruction in DE.
- DE_IR  out  32  instruction in DE.
- DE_V  out  1  DE latch valid.

## Operation
- States: FETCH, BR_WAIT. Reset: state FETCH, PC=RESET_PC, queue empty, outstanding=0, discard=0, DE_NPC=0, DE_IR=0, DE_V=0, IMEM_REQ=0.
- Queue: 2 entries of {npc[63:0], ir[31:0]}; count 0..2; rd/wr pointers wrap modulo 2.
- Issue: IMEM_REQ = (state==FETCH) && !outstanding && (count < 2) && !TRAP_V && !BR_RESOLVE_V. On IMEM_REQ && IMEM_GNT: PC <= PC+4 (64-bit wrap), outstanding <= 1, req_npc <= PC+4.
- Response: IMEM_RVALID clears outstanding. If discard=1, the word is dropped and discard clears; otherwise {req_npc, IMEM_RDATA} is pushed. A response never arrives when queue is full (issue rule guarantees room).
- DE load (when !V_MEM_STALL): if state==FETCH and count>0, pop head into DE_NPC/DE_IR, DE_V <= 1; else DE_V <= 0 (DE_NPC/DE_IR hold). V_MEM_STALL=1: DE latch and queue head held; fetch and responses continue.
- Branch detect: DE_V && V_DE_BR_STALL && state==FETCH: state <= BR_WAIT, save fallthrough <= DE_NPC, flush queue, discard <= outstanding (or pending response this cycle marked dropped), DE_V <= 0 at next load.
- BR_WAIT: no requests, DE_V <= 0. On BR_RESOLVE_V: PC <= BR_TAKEN ? BR_TARGET : fallthrough; state <= FETCH.
- Trap: TRAP_V: PC <= TRAP_PC, flush queue, discard <= outstanding && !IMEM_RVALID, DE_V <= 0, state <= FETCH.
- Priority: RESET > TRAP_V > BR_RESOLVE_V > branch detect > normal.
- TRAP_V or BR_RESOLVE_V coincident with IMEM_RVALID: response dropped, discard stays 0.

## Timing
- Request granted cycle N; response earliest N+1; word pushed at end of that cycle; DE_V high after the following edge (min 3 cycles request-to-DE). No queue bypass.
- Steady state: one instruction per 2 cycles with 1-cycle memory (single outstanding request).
- Redirect (trap or resolve) in cycle N: IMEM_ADDR shows new PC in N+1.
- Reset mid-operation: all state returns to reset values at the next edge; in-flight response after reset is dropped via discard=0 ignored only if outstanding=0 (response with outstanding=0 is ignored).

## Configuration
- FETCH_BUBBLE_CNT_EN: defined adds output BUBBLE_CNT (64) counting cycles where !V_MEM_STALL and DE loads DE_V=0; reset 0, wraps. Undefined: port and counter absent; no other behaviour change.

## Test plan
- Reset with RESET_PC=64'h1000, 1-cycle memory -> IMEM_ADDR 1000,1004,1008; DE_NPC 1004,1008,100C with matching DE_IR; DE_V=0 in first 3 cycles.
- V_MEM_STALL high 4 cycles while queue fills -> DE_IR held, count reaches 2, IMEM_REQ low; release -> queued words delivered in order, none lost.
- Branch at 1008 in DE (DE_NPC=100C) -> DE_V=0 until resolve; BR_TAKEN=1, target 2000 -> next IMEM_ADDR 2000; repeat BR_TAKEN=0 -> next IMEM_ADDR 100C.
- TRAP_V with TRAP_PC=8000 while request outstanding -> stale response dropped, queue empty, first DE_IR from 8000 with DE_NPC=8004.
- TRAP_V and BR_RESOLVE_V same cycle (target 2000, trap 8000) -> IMEM_ADDR 8000.
- With FETCH_BUBBLE_CNT_EN, 3-cycle memory latency, 10 cycles no stall -> BUBBLE_CNT equals count of DE_V=0 loads observed.
